multicycle_sequencer: RTL

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for a small RV-style datapath: fetch, decode,
// execute, memory and write-back with bounded memory handshakes and a sticky fault.
module multicycle_sequencer #(
    parameter int STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       rf_we,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CW = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] C_R      = 2'd0;
    localparam logic [1:0] C_LOAD   = 2'd1;
    localparam logic [1:0] C_STORE  = 2'd2;
    localparam logic [1:0] C_BRANCH = 2'd3;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_class;
    logic            r_fault;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      w_class_nxt;
    logic            w_fault_nxt;
    logic            w_retire;
    logic [2:0]      w_dec;
    logic [3:0]      w_ctrl;

    // Bit 2 flags a legal opcode; bits 1:0 carry its class.
    function automatic logic [2:0] decode_op(input logic [6:0] op);
        case (op)
            7'b0110011: return {1'b1, C_R};
            7'b0000011: return {1'b1, C_LOAD};
            7'b0100011: return {1'b1, C_STORE};
            7'b1100011: return {1'b1, C_BRANCH};
            default:    return 3'b000;
        endcase
    endfunction

    // Returns {alu_op, alu_src, mem_to_reg} for an instruction class.
    function automatic logic [3:0] class_ctrl(input logic [1:0] cls);
        case (cls)
            C_R:      return 4'b10_0_0;
            C_LOAD:   return 4'b00_1_1;
            C_STORE:  return 4'b00_1_0;
            C_BRANCH: return 4'b01_0_0;
            default:  return 4'b00_0_0;
        endcase
    endfunction

    // Next-state, wait-counter and output decode from the registered state.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_class_nxt  = r_class;
        w_fault_nxt  = r_fault;
        w_retire     = 1'b0;
        w_dec        = decode_op(opcode);
        w_ctrl       = 4'b0000;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        instr_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we       = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (r_cnt == CW'(STALL_LIMIT)) begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DECODE: begin
                if (w_dec[2]) begin
                    w_class_nxt = w_dec[1:0];
                    w_ctrl      = class_ctrl(w_dec[1:0]);
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                end
            end
            S_EXEC: begin
                w_ctrl = class_ctrl(r_class);
                case (r_class)
                    C_R: w_state_nxt = S_WB;
                    C_LOAD, C_STORE: begin
                        w_state_nxt = S_MEM;
                        w_cnt_nxt   = {CW{1'b0}};
                    end
                    C_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_sel   = branch_taken;
                        w_retire = 1'b1;
                    end
                    default: begin
                        w_state_nxt = S_HALT;
                        w_fault_nxt = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                w_ctrl   = class_ctrl(r_class);
                dmem_req = 1'b1;
                dmem_we  = (r_class == C_STORE);
                if (dmem_ack) begin
                    if (r_class == C_STORE) begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (r_cnt == CW'(STALL_LIMIT)) begin
                    w_state_nxt = S_HALT;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WB: begin
                w_ctrl   = class_ctrl(r_class);
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                w_retire = 1'b1;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_HALT;
                w_fault_nxt = 1'b1;
            end
        endcase
        // Retirement overrides the per-state choice: stop is only honoured here.
        if (w_retire) begin
            instr_done  = 1'b1;
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = stop ? S_IDLE : S_FETCH;
        end else begin
            instr_done = 1'b0;
        end
        alu_op     = w_ctrl[3:2];
        alu_src    = w_ctrl[1];
        mem_to_reg = w_ctrl[0];
    end

    // State, wait counter, instruction class and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_class <= C_R;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_class <= w_class_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign fault = r_fault;
    assign state = r_state;

endmodule
